rob_buffer: RTL and testbench
=============================

# rob_buffer

Reorder buffer for the dual-issue out-of-order core. It accepts up to two dispatched `rob_entry_t` records per cycle from decode/dispatch and supplies the `rob_tail_o` index that dispatch stamps into each issue-bus `rob_entry_num`. It marks entries complete from two writeback ports and retires up to two entries per cycle in program order to the rename free list and store buffer. An excepting entry at retirement flushes the whole buffer.

## Interface
- `ROB_DEPTH`, 16: number of entries; must be a power of two.
- `IDX_W`, 4: index width, `$clog2(ROB_DEPTH)`.
- `clk  in  1`: clock.
- `resetn  in  1`: asynchronous active-low reset.
- `flush  in  1`: external pipeline flush, for example an eret redirect.
- `map_to_rob_bus1  in  rob_entry_t`: dispatch slot 1. Valid when `state != Inst_Invalid`.
- `map_to_rob_bus2  in  rob_entry_t`: dispatch slot 2. It is never valid unless slot 1 is valid.
- `rob_tail_o  out  IDX_W`: next allocation index.
- `rob_ready  out  1`: at least 2 free entries (count ≤ ROB_DEPTH−2).
- `rob_empty  out  1`: count == 0.
- `wb1_valid`, `wb2_valid  in  1`: completion strobes.
- `wb1_rob_num`, `wb2_rob_num  in  IDX_W`: completing entry index.
- `wb1_exception`, `wb2_exception  in  exception_t`: execute-stage exception to merge.
- `commit1_valid`, `commit2_valid  out  1`: retire strobes.
- `commit1_entry`, `commit2_entry  out  rob_entry_t`: retiring records, carrying `dest`, `phy_dest`, `old_dest`, `rf_we` and `is_store_op`.
- `commit_exception_valid  out  1`: slot-1 retirement carries `exception.ex`.
- `commit_exception  out  exception_t`: exception of the slot-1 retiring entry.

## Operation
- **Storage:** `ROB_DEPTH` entries, head/tail pointers of `IDX_W` bits, and a count of `IDX_W+1` bits. Pointers wrap modulo `ROB_DEPTH`.
- **Allocation:**
  - A valid slot 1 is written at `tail`, and a valid slot 2 at `tail+1`.
  - `tail` advances by the number of valid slots, and the stored `state` is copied from the bus.
  - Dispatch presents valid slots only while `rob_ready` is 1. If it presents them while not ready, they are dropped.
- **Writeback:**
  - A valid port whose target entry has `state == Inst_Wait` sets the state to `Inst_Complete`.
  - It ORs `wb_exception` into the entry when `wb_exception.ex` is set.
  - A writeback to an `Inst_Invalid` entry is ignored.
  - Both ports may hit different entries in the same cycle. Two strobes to the same index are illegal.
- **Commit:** combinational from registered state.
  - Slot 1 retires when the head entry is `Inst_Complete`.
  - Slot 2 retires entry `head+1` when all of the following hold:
    - slot 1 retires;
    - the head entry has no exception;
    - entry `head+1` is `Inst_Complete` with no exception;
    - the two entries are not both stores.
  - Retired entries become `Inst_Invalid`, `head` advances by the number retired, and count is updated by +alloc −commit in the same edge.
- **Exception:**
  - When the head entry retires with `exception.ex`, assert `commit1_valid` and `commit_exception_valid`, and suppress slot 2.
  - At that edge, take the flush action.
- **Flush (exception or `flush`):**
  - All entries become `Inst_Invalid`, and head, tail and count go to 0.
  - Allocation and writeback in the flush cycle are discarded.

## Timing
- **Reset values:**
  - `rob_tail_o` = 0, `rob_ready` = 1, `rob_empty` = 1.
  - All commit outputs = 0, and all entries = `Inst_Invalid`.
- **Allocation to tail:** an allocation at edge N is visible in `rob_tail_o` and count after edge N.
- **Completion to retirement:** writeback at edge N allows the entry to retire in cycle N+1 at the earliest. No same-cycle writeback-to-commit bypass exists.
- **Entry reuse:** allocation and retirement of the same index in one cycle is impossible, because `rob_ready` keeps 2 entries spare.
- **Flush:** takes effect at the edge it is sampled on. The ROB is empty in the following cycle.
- **Reset mid-operation:** the asynchronous clear overrides all activity. `rob_ready` rises immediately.

## Configuration
- **`ROB_DUAL_COMMIT_EN` defined:** up to two retirements per cycle, as described above.
- **`ROB_DUAL_COMMIT_EN` undefined:**
  - `commit2_valid` is tied to 0, and at most one entry retires per cycle.
  - Port `commit2_entry` remains present and is driven with zeros.

## Test plan
- **Reset:** assert `resetn`=0 mid-stream, then release → `rob_tail_o`=0, `rob_empty`=1, `rob_ready`=1, no commits.
- **Out-of-order completion:**
  - Stimulus: allocate two `Inst_Wait` entries (phy_dest 33/34, old_dest 5/6), then wb entry 1 at cycle 2 and entry 0 at cycle 3.
  - Response: both commit in cycle 4, with `commit1_entry.old_dest`=5 and `commit2_entry.old_dest`=6.
- **Full and wrap-around:**
  - Allocate 7 pairs with no completion → count 14, `rob_ready`=1.
  - An 8th pair is dropped once `rob_ready`=0 is checked at count 15 via a single allocation.
  - Complete all entries and retire them, then allocate again → tail wraps 15→0.
- **Dispatched exception:** allocate entry 0 as `Inst_Complete` with `exception.ex`=1 plus a second `Inst_Wait` entry → next cycle `commit1_valid`=1, `commit_exception_valid`=1, `commit2_valid`=0; the cycle after, `rob_empty`=1 and `rob_tail_o`=0.
- **Store pair:** two completed stores at the head → retire in two consecutive cycles, one per cycle.
- **`ROB_DUAL_COMMIT_EN` off:** four completed entries → one commit per cycle over 4 cycles, with `commit2_valid` never asserted.

Source files
------------

// File: rtl/rob_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rob_buffer                                                      |
// | Purpose  : Dual-dispatch reorder buffer. Allocates up to two entries per   |
// |            cycle, marks them complete from two writeback ports and         |
// |            retires in program order. An excepting head entry flushes the   |
// |            whole buffer.                                                   |
// | Config   : ROB_DUAL_COMMIT_EN - when defined, up to two retirements per    |
// |            cycle; otherwise one, with commit2_* driven to zero.            |
// | Ports    : clk, resetn (async, active low), flush                          |
// |            map_to_rob_bus1/2       - dispatch slots (valid: state!=Invalid)|
// |            rob_tail_o              - next allocation index                 |
// |            rob_ready / rob_empty   - >=2 free entries / no entries         |
// |            wb1/wb2_valid, _rob_num, _exception - completion ports          |
// |            commit1/2_valid, _entry - in-order retirement                   |
// |            commit_exception_valid, commit_exception - slot-1 exception     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

package rob_pkg;
  typedef enum logic [1:0] {
    Inst_Invalid  = 2'd0,
    Inst_Wait     = 2'd1,
    Inst_Complete = 2'd2
  } inst_state_t;

  typedef struct packed {
    logic       ex;
    logic [4:0] code;
  } exception_t;

  typedef struct packed {
    inst_state_t state;
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [5:0]  phy_dest;
    logic [5:0]  old_dest;
    logic        rf_we;
    logic        is_store_op;
    exception_t  exception;
  } rob_entry_t;
endpackage

module rob_buffer
  import rob_pkg::*;
#(
  parameter int ROB_DEPTH = 16,
  parameter int IDX_W     = $clog2(ROB_DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  rob_entry_t       map_to_rob_bus1,
  input  rob_entry_t       map_to_rob_bus2,
  output logic [IDX_W-1:0] rob_tail_o,
  output logic             rob_ready,
  output logic             rob_empty,
  input  logic             wb1_valid,
  input  logic [IDX_W-1:0] wb1_rob_num,
  input  exception_t       wb1_exception,
  input  logic             wb2_valid,
  input  logic [IDX_W-1:0] wb2_rob_num,
  input  exception_t       wb2_exception,
  output logic             commit1_valid,
  output logic             commit2_valid,
  output rob_entry_t       commit1_entry,
  output rob_entry_t       commit2_entry,
  output logic             commit_exception_valid,
  output exception_t       commit_exception
);

  localparam logic [IDX_W:0]   c_ready_max = (IDX_W+1)'(ROB_DEPTH - 2);
  localparam logic [IDX_W-1:0] c_idx_one   = IDX_W'(1);

  rob_entry_t       r_entries [ROB_DEPTH];
  logic [IDX_W-1:0] r_head;
  logic [IDX_W-1:0] r_tail;
  logic [IDX_W:0]   r_count;

  rob_entry_t       w_head_entry;
  logic [IDX_W-1:0] w_head_plus1;
  logic [IDX_W-1:0] w_tail_plus1;
  logic             w_alloc1;
  logic             w_alloc2;
  logic             w_commit1;
  logic             w_commit2;
  logic             w_exc;
  logic             w_flush_all;
  logic [IDX_W:0]   w_alloc_n;
  logic [IDX_W:0]   w_commit_n;

  assign w_head_entry = r_entries[r_head];
  assign w_head_plus1 = r_head + c_idx_one;
  assign w_tail_plus1 = r_tail + c_idx_one;

  assign rob_tail_o = r_tail;
  assign rob_ready  = (r_count <= c_ready_max);
  assign rob_empty  = (r_count == '0);

  // Slot 2 is only honoured alongside slot 1, and nothing is taken while
  // the buffer lacks two spare entries.
  assign w_alloc1  = rob_ready && (map_to_rob_bus1.state != Inst_Invalid);
  assign w_alloc2  = w_alloc1  && (map_to_rob_bus2.state != Inst_Invalid);
  assign w_alloc_n = (IDX_W+1)'(w_alloc1) + (IDX_W+1)'(w_alloc2);

  // Free entries are always Inst_Invalid, so the head state alone decides
  // retirement without consulting the count.
  assign w_commit1 = (w_head_entry.state == Inst_Complete);

`ifdef ROB_DUAL_COMMIT_EN
  rob_entry_t w_next_entry;
  assign w_next_entry = r_entries[w_head_plus1];
  assign w_commit2 = w_commit1 && !w_head_entry.exception.ex &&
                     (w_next_entry.state == Inst_Complete) &&
                     !w_next_entry.exception.ex &&
                     !(w_head_entry.is_store_op && w_next_entry.is_store_op);
  assign commit2_entry = w_commit2 ? w_next_entry : '0;
`else
  assign w_commit2     = 1'b0;
  assign commit2_entry = '0;
`endif

  assign w_commit_n = (IDX_W+1)'(w_commit1) + (IDX_W+1)'(w_commit2);

  assign commit1_valid          = w_commit1;
  assign commit2_valid          = w_commit2;
  assign commit1_entry          = w_commit1 ? w_head_entry : '0;
  assign w_exc                  = w_commit1 && w_head_entry.exception.ex;
  assign commit_exception_valid = w_exc;
  assign commit_exception       = w_commit1 ? w_head_entry.exception : '0;

  assign w_flush_all = flush || w_exc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ROB_DEPTH; i++) r_entries[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_flush_all) begin
      // Allocation and writeback arriving in the flush cycle are discarded.
      for (int i = 0; i < ROB_DEPTH; i++) r_entries[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_commit1) r_entries[r_head].state       <= Inst_Invalid;
      if (w_commit2) r_entries[w_head_plus1].state <= Inst_Invalid;

      // Retiring entries are Complete and allocation targets are Invalid,
      // so a Wait-state writeback never collides with either.
      if (wb1_valid && (r_entries[wb1_rob_num].state == Inst_Wait)) begin
        r_entries[wb1_rob_num].state <= Inst_Complete;
        if (wb1_exception.ex)
          r_entries[wb1_rob_num].exception <= r_entries[wb1_rob_num].exception | wb1_exception;
      end
      if (wb2_valid && (r_entries[wb2_rob_num].state == Inst_Wait)) begin
        r_entries[wb2_rob_num].state <= Inst_Complete;
        if (wb2_exception.ex)
          r_entries[wb2_rob_num].exception <= r_entries[wb2_rob_num].exception | wb2_exception;
      end

      if (w_alloc1) r_entries[r_tail]       <= map_to_rob_bus1;
      if (w_alloc2) r_entries[w_tail_plus1] <= map_to_rob_bus2;

      r_head  <= r_head + w_commit_n[IDX_W-1:0];
      r_tail  <= r_tail + w_alloc_n[IDX_W-1:0];
      r_count <= r_count + w_alloc_n - w_commit_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rob_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_rob_buffer                                                   |
// | Purpose  : Self-checking bench for rob_buffer. A queue-based program-order |
// |            model predicts every output each cycle; directed scenarios are  |
// |            followed by randomized dispatch/writeback/flush traffic.        |
// | Config   : honours ROB_DUAL_COMMIT_EN the same way as the design.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_rob_buffer;
  import rob_pkg::*;

  localparam int DEPTH = 16;
  localparam int IW    = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          flush;
  rob_entry_t    map_to_rob_bus1, map_to_rob_bus2;
  logic [IW-1:0] rob_tail_o;
  logic          rob_ready, rob_empty;
  logic          wb1_valid, wb2_valid;
  logic [IW-1:0] wb1_rob_num, wb2_rob_num;
  exception_t    wb1_exception, wb2_exception;
  logic          commit1_valid, commit2_valid;
  rob_entry_t    commit1_entry, commit2_entry;
  logic          commit_exception_valid;
  exception_t    commit_exception;

  rob_buffer #(.ROB_DEPTH(DEPTH), .IDX_W(IW)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .map_to_rob_bus1(map_to_rob_bus1), .map_to_rob_bus2(map_to_rob_bus2),
    .rob_tail_o(rob_tail_o), .rob_ready(rob_ready), .rob_empty(rob_empty),
    .wb1_valid(wb1_valid), .wb1_rob_num(wb1_rob_num), .wb1_exception(wb1_exception),
    .wb2_valid(wb2_valid), .wb2_rob_num(wb2_rob_num), .wb2_exception(wb2_exception),
    .commit1_valid(commit1_valid), .commit2_valid(commit2_valid),
    .commit1_entry(commit1_entry), .commit2_entry(commit2_entry),
    .commit_exception_valid(commit_exception_valid), .commit_exception(commit_exception)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: in-order list of live entries, oldest first, plus head/tail index.
  rob_entry_t mq[$];
  int m_head = 0;
  int m_tail = 0;

  // Stimulus for the next edge.
  rob_entry_t s_b1, s_b2;
  logic s_w1v, s_w2v, s_fl;
  logic [IW-1:0] s_w1n, s_w2n;
  exception_t s_w1e, s_w2e;

  function automatic rob_entry_t mk(input inst_state_t st, input logic [5:0] phy,
                                    input logic [5:0] old, input logic st_op, input logic ex);
    rob_entry_t e;
    e = '0;
    e.state          = st;
    e.pc             = 32'h1000 + 32'(phy) * 4;
    e.dest           = old[4:0];
    e.phy_dest       = phy;
    e.old_dest       = old;
    e.rf_we          = !st_op;
    e.is_store_op    = st_op;
    e.exception.ex   = ex;
    e.exception.code = ex ? 5'd2 : 5'd0;
    return e;
  endfunction

  task automatic clear_stim();
    s_b1 = '0; s_b2 = '0; s_fl = 1'b0;
    s_w1v = 1'b0; s_w1n = '0; s_w1e = '0;
    s_w2v = 1'b0; s_w2n = '0; s_w2e = '0;
  endtask

  task automatic model_wb(input logic v, input logic [IW-1:0] n, input exception_t e);
    int pos;
    if (!v) return;
    pos = (int'(n) - m_head + DEPTH) % DEPTH;
    if (pos < mq.size() && mq[pos].state == Inst_Wait) begin
      mq[pos].state = Inst_Complete;
      if (e.ex) mq[pos].exception = exception_t'(mq[pos].exception | e);
    end
  endtask

  // Compare DUT outputs with the model's view, then advance the model by
  // the stimulus currently presented.
  task automatic check_and_update();
    int sz = mq.size();
    bit c1 = 0, c2 = 0, exc = 0;
    rob_entry_t e1 = '0, e2 = '0;
    exception_t ee = '0;
    if (sz > 0 && mq[0].state == Inst_Complete) begin
      c1 = 1; e1 = mq[0]; ee = mq[0].exception; exc = mq[0].exception.ex;
`ifdef ROB_DUAL_COMMIT_EN
      if (sz > 1 && !mq[0].exception.ex && mq[1].state == Inst_Complete &&
          !mq[1].exception.ex && !(mq[0].is_store_op && mq[1].is_store_op)) begin
        c2 = 1; e2 = mq[1];
      end
`endif
    end
    check_eq("rob_tail_o", 64'(rob_tail_o), 64'(m_tail));
    check_eq("rob_ready", 64'(rob_ready), 64'(sz <= DEPTH - 2));
    check_eq("rob_empty", 64'(rob_empty), 64'(sz == 0));
    check_eq("commit1_valid", 64'(commit1_valid), 64'(c1));
    check_eq("commit2_valid", 64'(commit2_valid), 64'(c2));
    check_eq("commit1_entry", 64'(commit1_entry), 64'(e1));
    check_eq("commit2_entry", 64'(commit2_entry), 64'(e2));
    check_eq("commit_exception_valid", 64'(commit_exception_valid), 64'(exc));
    check_eq("commit_exception", 64'(commit_exception), 64'(ee));

    if (s_fl || exc) begin
      mq.delete(); m_head = 0; m_tail = 0;
    end else begin
      model_wb(s_w1v, s_w1n, s_w1e);
      model_wb(s_w2v, s_w2n, s_w2e);
      if (c1) begin void'(mq.pop_front()); m_head = (m_head + 1) % DEPTH; end
      if (c2) begin void'(mq.pop_front()); m_head = (m_head + 1) % DEPTH; end
      if (sz <= DEPTH - 2 && s_b1.state != Inst_Invalid) begin
        mq.push_back(s_b1); m_tail = (m_tail + 1) % DEPTH;
        if (s_b2.state != Inst_Invalid) begin
          mq.push_back(s_b2); m_tail = (m_tail + 1) % DEPTH;
        end
      end
    end
  endtask

  task automatic step();
    map_to_rob_bus1 = s_b1; map_to_rob_bus2 = s_b2; flush = s_fl;
    wb1_valid = s_w1v; wb1_rob_num = s_w1n; wb1_exception = s_w1e;
    wb2_valid = s_w2v; wb2_rob_num = s_w2n; wb2_exception = s_w2e;
    @(negedge clk);
    check_and_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin clear_stim(); step(); end
  endtask

  task automatic wb_one(input int idx);
    clear_stim(); s_w1v = 1'b1; s_w1n = IW'(idx); step();
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_tail", 64'(rob_tail_o), 64'd0);
    check_eq("rst_ready", 64'(rob_ready), 64'd1);
    check_eq("rst_empty", 64'(rob_empty), 64'd1);
    check_eq("rst_commit1", 64'(commit1_valid), 64'd0);
    check_eq("rst_commit2", 64'(commit2_valid), 64'd0);
    check_eq("rst_commit_exc", 64'(commit_exception_valid), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_stim();
    resetn = 1'b0;
    map_to_rob_bus1 = '0; map_to_rob_bus2 = '0; flush = 1'b0;
    wb1_valid = 1'b0; wb1_rob_num = '0; wb1_exception = '0;
    wb2_valid = 1'b0; wb2_rob_num = '0; wb2_exception = '0;
    @(posedge clk); @(posedge clk); #1;
    check_reset_outputs();
    resetn = 1'b1;
    idle(1);

    // Out-of-order completion: entry 1 completes before entry 0.
    clear_stim();
    s_b1 = mk(Inst_Wait, 6'd33, 6'd5, 1'b0, 1'b0);
    s_b2 = mk(Inst_Wait, 6'd34, 6'd6, 1'b0, 1'b0);
    step();
    idle(1);
    wb_one(1);
    wb_one(0);
    idle(3);

    // Fill: seven pairs, one single, then a pair that must be dropped.
    for (int i = 0; i < 7; i++) begin
      clear_stim();
      s_b1 = mk(Inst_Wait, 6'(2 * i), 6'(i), 1'b0, 1'b0);
      s_b2 = mk(Inst_Wait, 6'(2 * i + 1), 6'(i + 8), 1'b0, 1'b0);
      step();
    end
    clear_stim(); s_b1 = mk(Inst_Wait, 6'd40, 6'd20, 1'b0, 1'b0); step();
    clear_stim();
    s_b1 = mk(Inst_Wait, 6'd41, 6'd21, 1'b0, 1'b0);
    s_b2 = mk(Inst_Wait, 6'd42, 6'd22, 1'b0, 1'b0);
    step();
    for (int k = 0; k < 15; k++) wb_one((m_head + k) % DEPTH);
    idle(16);
    for (int i = 0; i < 3; i++) begin
      clear_stim();
      s_b1 = mk(Inst_Complete, 6'(50 + i), 6'(i), 1'b0, 1'b0);
      s_b2 = mk(Inst_Complete, 6'(54 + i), 6'(i + 4), 1'b0, 1'b0);
      step();
    end
    idle(6);

    // Dispatched exception at entry 0.
    clear_stim(); s_fl = 1'b1; step();
    clear_stim();
    s_b1 = mk(Inst_Complete, 6'd60, 6'd7, 1'b0, 1'b1);
    s_b2 = mk(Inst_Wait, 6'd61, 6'd8, 1'b0, 1'b0);
    step();
    idle(3);

    // Store pair at the head.
    clear_stim();
    s_b1 = mk(Inst_Complete, 6'd10, 6'd1, 1'b1, 1'b0);
    s_b2 = mk(Inst_Complete, 6'd11, 6'd2, 1'b1, 1'b0);
    step();
    idle(3);

    // Four completed entries.
    for (int i = 0; i < 2; i++) begin
      clear_stim();
      s_b1 = mk(Inst_Complete, 6'(20 + 2 * i), 6'(i), 1'b0, 1'b0);
      s_b2 = mk(Inst_Complete, 6'(21 + 2 * i), 6'(i + 2), 1'b0, 1'b0);
      step();
    end
    idle(5);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      int r, sz;
      clear_stim();
      r = int'($urandom_range(0, 9));
      if (r < 6) begin
        rob_entry_t e;
        for (int s = 0; s < 2; s++) begin
          e = $urandom;
          e.state = ($urandom_range(0, 4) == 0) ? Inst_Complete : Inst_Wait;
          e.exception = '0;
          if (e.state == Inst_Complete && $urandom_range(0, 19) == 0) begin
            e.exception.ex = 1'b1; e.exception.code = 5'($urandom);
          end
          if (s == 0) s_b1 = e;
          else if (r < 3) s_b2 = e;
        end
      end
      sz = (mq.size() == 0) ? DEPTH : mq.size();
      if ($urandom_range(0, 1) == 1) begin
        s_w1v = 1'b1; s_w1n = IW'((m_head + int'($urandom_range(0, sz - 1))) % DEPTH);
        if ($urandom_range(0, 19) == 0) s_w1e = '{ex: 1'b1, code: 5'($urandom)};
      end
      if ($urandom_range(0, 1) == 1) begin
        s_w2v = 1'b1; s_w2n = IW'((m_head + int'($urandom_range(0, sz - 1))) % DEPTH);
        if ($urandom_range(0, 19) == 0) s_w2e = '{ex: 1'b1, code: 5'($urandom)};
        if (s_w1v && s_w2n == s_w1n) s_w2v = 1'b0;
      end
      if ($urandom_range(0, 99) == 0) s_fl = 1'b1;
      step();
    end

    // Reset in the middle of traffic.
    for (int i = 0; i < 7; i++) begin
      clear_stim();
      s_b1 = mk(Inst_Wait, 6'(i), 6'(i), 1'b0, 1'b0);
      s_b2 = mk(Inst_Wait, 6'(i + 30), 6'(i), 1'b0, 1'b0);
      step();
    end
    clear_stim();
    s_b1 = mk(Inst_Wait, 6'd45, 6'd3, 1'b0, 1'b0);
    map_to_rob_bus1 = s_b1;
    resetn = 1'b0;
    #1;
    check_reset_outputs();
    mq.delete(); m_head = 0; m_tail = 0;
    @(posedge clk); #1;
    resetn = 1'b1;
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
